// File: rtl/daq_ddu_sched_pkg.sv
// Shared types and constants for the DDU link scheduler and its output block.
package daq_ddu_sched_pkg;

  typedef enum logic [1:0] {
    STARTUP,
    IDLE,
    XFER,
    GAP
  } state_t;

  localparam int DDU_WORD_W = 16;
  localparam logic [DDU_WORD_W-1:0] IDLE2 = 16'h50BC;

  // Counter width for a count limit n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/daq_ddu_sched_if.sv
// Source-side handshake and DDU output-side signals of the link scheduler.
interface daq_ddu_sched_if #(
  parameter int NSRC = 4
);
  import daq_ddu_sched_pkg::*;

  logic [DDU_WORD_W*NSRC-1:0] src_data;
  logic [NSRC-1:0]            src_vld;
  logic [NSRC-1:0]            src_last;
  logic [NSRC-1:0]            src_rdy;
  logic [DDU_WORD_W-1:0]      txd;
  logic                       txd_vld;
  logic                       busy;
  logic                       abort;
  logic [15:0]                pkt_cnt;

  modport master (
    output src_data, src_vld, src_last,
    input  src_rdy, txd, txd_vld, busy, abort, pkt_cnt
  );

  modport slave (
    input  src_data, src_vld, src_last,
    output src_rdy, txd, txd_vld, busy, abort, pkt_cnt
  );

endinterface

// File: rtl/daq_ddu_sched_rr_arb.sv
// Combinational round-robin priority encoder: first request at or above ptr, wrapping.
module ddu_rr_arb #(
  parameter  int NSRC = 4,
  localparam int IW   = $clog2(NSRC)
) (
  input  logic [NSRC-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NSRC-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int s;
    s   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      s = (int'(ptr) + k) % NSRC;
      if (!any && req[s]) begin
        any    = 1'b1;
        gnt[s] = 1'b1;
        idx    = IW'(s);
      end
    end
  end

endmodule

// File: rtl/daq_ddu_sched.sv
// Shares the DDU output link among NSRC packet sources, one packet per grant.
//   state   | meaning
//   STARTUP | link-sync idle after reset, no grants
//   IDLE    | arbitration cycle, grant latched when any source requests
//   XFER    | forward granted source's words, watch for stall timeout
//   GAP     | forced inter-packet idle
module daq_ddu_sched
  import daq_ddu_sched_pkg::*;
#(
  parameter int NSRC         = 4,
  parameter int STARTUP_IDLE = 1024,
  parameter int GAP_CYCLES   = 2,
  parameter int STALL_TMO    = 4096
) (
  input logic              clk,
  input logic              rst_n,
  daq_ddu_sched_if.slave   bus
);

  localparam int IW   = $clog2(NSRC);
  localparam int SU_W = cnt_w(STARTUP_IDLE);
  localparam int GP_W = cnt_w(GAP_CYCLES);
  localparam int ST_W = cnt_w(STALL_TMO);
  localparam logic [SU_W-1:0] SU_LAST  = SU_W'(STARTUP_IDLE - 1);
  localparam logic [GP_W-1:0] GP_LOAD  = GP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ST_W-1:0] ST_LAST  = ST_W'(STALL_TMO - 1);
  localparam state_t          POST_PKT = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t                state_q, state_d;
  logic [SU_W-1:0]       su_q;
  logic [GP_W-1:0]       gap_q;
  logic [ST_W-1:0]       stall_q;
  logic [IW-1:0]         grant_q, ptr_q, ptr_nxt, arb_idx;
  logic [NSRC-1:0]       grant_oh_q, arb_gnt, rdy;
  logic                  arb_any;
  logic [DDU_WORD_W-1:0] word, txd_q;
  logic                  txd_vld_q, abort_q;
  logic [15:0]           pkt_cnt_q;
  logic                  vld_g, last_g, accept, timeout, pkt_done;

  ddu_rr_arb #(.NSRC(NSRC)) u_arb (
    .req (bus.src_vld),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    word = '0;
    for (int i = 0; i < NSRC; i++)
      if (grant_q == IW'(i)) word = bus.src_data[i*DDU_WORD_W +: DDU_WORD_W];
  end

  assign vld_g    = bus.src_vld[grant_q];
  assign last_g   = bus.src_last[grant_q];
  assign accept   = (state_q == XFER) && vld_g;
  // An accept always clears the stall count, so it wins over a coincident timeout.
  assign timeout  = (state_q == XFER) && !vld_g && (stall_q == ST_LAST);
  assign pkt_done = (accept && last_g) || timeout;
  assign ptr_nxt  = (grant_q == IW'(NSRC - 1)) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STARTUP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rdy     = '0;
    case (state_q)
      STARTUP: if (su_q == SU_LAST) state_d = IDLE;
      IDLE:    if (arb_any) state_d = XFER;
      XFER: begin
        rdy = grant_oh_q;
        if (pkt_done) state_d = POST_PKT;
      end
      GAP:     if (gap_q == '0) state_d = IDLE;
      default: state_d = STARTUP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_q       <= '0;
      gap_q      <= '0;
      stall_q    <= '0;
      grant_q    <= '0;
      grant_oh_q <= '0;
      ptr_q      <= '0;
      txd_q      <= '0;
      txd_vld_q  <= 1'b0;
      abort_q    <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      txd_vld_q <= accept;
      abort_q   <= timeout;
      if (accept) txd_q <= word;
      if (state_q == STARTUP) su_q <= su_q + 1'b1;
      if (state_q == IDLE && arb_any) begin
        grant_q    <= arb_idx;
        grant_oh_q <= arb_gnt;
      end
      if (pkt_done) begin
        ptr_q     <= ptr_nxt;
        pkt_cnt_q <= pkt_cnt_q + 16'd1;
      end
      if (state_q != XFER || accept) stall_q <= '0;
      else                           stall_q <= stall_q + 1'b1;
      // Down-counter preloaded during XFER so GAP lasts exactly GAP_CYCLES.
      if (state_q == XFER)                      gap_q <= GP_LOAD;
      else if (state_q == GAP && gap_q != '0)   gap_q <= gap_q - 1'b1;
    end
  end

  assign bus.src_rdy = rdy;
  assign bus.txd     = txd_q;
  assign bus.txd_vld = txd_vld_q;
  assign bus.busy    = (state_q == XFER);
  assign bus.abort   = abort_q;
  assign bus.pkt_cnt = pkt_cnt_q;

endmodule
